// File: rtl/fixed_sqrt_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fixed_sqrt_arbiter_pkg
// Shared definitions for the fixed-point square-root arbiter:
//   - fixed_t   : 32-bit two's complement fixed point, FRAC_BITS fractional bits
//   - state_t   : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   - is_negative() : sign test used by the optional negative-radicand check
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package fixed_sqrt_arbiter_pkg;

  localparam int FIX_W     = 32;
  localparam int FRAC_BITS = 14;

  typedef logic signed [FIX_W-1:0] fixed_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // A radicand with the sign bit set has no real square root.
  function automatic logic is_negative(input fixed_t v);
    return v[FIX_W-1];
  endfunction

endpackage

// File: rtl/fixed_sqrt_rr_pick.sv
// -----------------------------------------------------------------------------
// fixed_sqrt_rr_pick
// Purely combinational round-robin picker. Searches the request vector starting
// at position ptr and wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   req   [NUM_REQ-1:0]  in   request vector
//   ptr   [IDX_W-1:0]    in   search start position (must be < NUM_REQ)
//   grant [NUM_REQ-1:0]  out  one-hot winner (zero when no request)
//   idx   [IDX_W-1:0]    out  winner index (zero when no request)
//   found                out  at least one request present
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fixed_sqrt_rr_pick
  import fixed_sqrt_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Wrap without a modulo operator: ptr + i is always below 2*NUM_REQ.
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fixed_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// fixed_sqrt_arbiter
// Shares one external fixed-point square-root unit among NUM_REQ requesters.
// One operation is in flight at a time; requesters are served round-robin.
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Ports:
//   clk                         in   single clock, rising edge
//   resetn                      in   asynchronous active-low reset
//   req_valid [NUM_REQ]         in   per-requester request
//   req_rad   [NUM_REQ] fixed_t in   per-requester radicand
//   req_ready [NUM_REQ]         out  accept, one-hot or zero, IDLE only
//   rsp_valid [NUM_REQ]         out  one-cycle one-hot result pulse
//   rsp_root  fixed_t           out  shared result bus (holds last value)
//   rsp_err                     out  rejected radicand, qualified by rsp_valid
//   sq_strobe                   out  start pulse to the sqrt unit
//   sq_rad    fixed_t           out  radicand to the sqrt unit (holds last value)
//   sq_root   fixed_t           in   result from the sqrt unit
//   sq_valid                    in   completion from the sqrt unit (WAIT only)
//   busy                        out  high whenever the FSM is not IDLE
//
// Build option: define FIXED_SQRT_NEG_CHECK_EN to reject radicands with bit 31
// set directly from IDLE to RESP (no strobe, root 0, rsp_err 1). Without it,
// every request goes to the unit and rsp_err is tied low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fixed_sqrt_arbiter
  import fixed_sqrt_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  fixed_t [NUM_REQ-1:0] req_rad,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output fixed_t               rsp_root,
  output logic                 rsp_err,
  output logic                 sq_strobe,
  output fixed_t               sq_rad,
  input  fixed_t               sq_root,
  input  logic                 sq_valid,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  fixed_t             rad_q;
  fixed_t             root_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               in_idle;
  logic               handshake;
  logic               neg_reject;
  fixed_t             win_rad;

  fixed_sqrt_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // resetn gates ready so nothing is offered while reset is held.
  assign in_idle   = (state == IDLE) && resetn;
  assign req_ready = in_idle ? grant : '0;
  assign handshake = in_idle && pick_found;
  assign win_rad   = req_rad[pick_idx];

`ifdef FIXED_SQRT_NEG_CHECK_EN
  logic err_q;
  assign neg_reject = handshake && is_negative(win_rad);
  assign rsp_err    = err_q && (state == RESP);
`else
  assign neg_reject = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = neg_reject ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (sq_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sq_strobe = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign sq_rad    = rad_q;
  assign rsp_root  = root_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      rad_q  <= '0;
      root_q <= '0;
`ifdef FIXED_SQRT_NEG_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      // accept: remember who owns the operation and what goes to the unit
      if (handshake) owner <= pick_idx;
      // rejected radicands never reach sq_rad, so it keeps the last issued value
      if (handshake && !neg_reject) rad_q <= win_rad;

      // completion: sq_valid only matters while waiting
      if ((state == WAIT) && sq_valid) root_q <= sq_root;

`ifdef FIXED_SQRT_NEG_CHECK_EN
      if (handshake) begin
        err_q <= neg_reject;
        if (neg_reject) root_q <= '0;
      end
`endif

      // response: next search starts just past the requester served
      if (state == RESP) begin
        ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fixed_sqrt_arbiter.sv
`timescale 1ns/1ps

module tb_fixed_sqrt_arbiter;
  import fixed_sqrt_arbiter_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_valid;
  fixed_t [N-1:0] req_rad;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  fixed_t         rsp_root;
  logic           rsp_err;
  logic           sq_strobe;
  fixed_t         sq_rad;
  fixed_t         sq_root;
  logic           sq_valid;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int rsp_cnt    = 0;
  int multi_cnt  = 0;

  fixed_sqrt_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_rad   (req_rad),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_root  (rsp_root),
    .rsp_err   (rsp_err),
    .sq_strobe (sq_strobe),
    .sq_rad    (sq_rad),
    .sq_root   (sq_root),
    .sq_valid  (sq_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sq_strobe) strobe_cnt <= strobe_cnt + 1;
    if (|rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if ($countones(req_ready) > 1) multi_cnt <= multi_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn    = 1'b0;
    req_valid = '0;
    sq_valid  = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // Plays the external sqrt unit: takes the handshake edge, waits for the
  // strobe, then returns root after lat WAIT cycles. Leaves the bench in RESP.
  task automatic serve(input fixed_t root, input int lat, input logic [N-1:0] drop);
    int guard;
    guard = 0;
    step();
    req_valid = req_valid & ~drop;
    while (!sq_strobe && guard < 20) begin
      step();
      guard++;
    end
    if (!sq_strobe) begin
      n_checks++;
      n_fail++;
      $display("FAIL serve_strobe_timeout no sq_strobe within 20 cycles");
    end
    step();
    repeat (lat - 1) step();
    sq_valid = 1'b1;
    sq_root  = root;
    step();
    sq_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn    = 1'b0;
    req_valid = '1;
    req_rad   = '0;
    sq_valid  = 1'b1;
    sq_root   = 32'sh0000_5555;
    step();
    step();
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    n_checks++; if (rsp_root !== 32'sh0) begin n_fail++; $display("FAIL reset_rsp_root got %h want 0", rsp_root); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    n_checks++; if (sq_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_sq_strobe got %b want 0", sq_strobe); end
    n_checks++; if (sq_rad !== 32'sh0) begin n_fail++; $display("FAIL reset_sq_rad got %h want 0", sq_rad); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    req_valid = '0;
    sq_valid  = 1'b0;
    resetn    = 1'b1;
    step();
  endtask

  // Port 0 requests 3.0 (0xC000), unit answers sqrt = 0x6ED9 after 3 cycles.
  task automatic test_single;
    int bs, br;
    bs = strobe_cnt;
    br = rsp_cnt;
    req_rad[0] = 32'sh0000_C000;
    req_valid  = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b want 0001", req_ready); end
    serve(32'sh0000_6ED9, 3, 4'b0001);
    n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid got %b want 0001", rsp_valid); end
    n_checks++; if (rsp_root !== 32'sh0000_6ED9) begin n_fail++; $display("FAIL single_rsp_root got %h want 00006ed9", rsp_root); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp_err got %b want 0", rsp_err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_resp got %b want 1", busy); end
    step();
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_pulse got %b want 0000", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", busy); end
    n_checks++; if (rsp_root !== 32'sh0000_6ED9) begin n_fail++; $display("FAIL single_root_hold got %h want 00006ed9", rsp_root); end
    n_checks++; if (sq_rad !== 32'sh0000_C000) begin n_fail++; $display("FAIL single_sq_rad got %h want 0000c000", sq_rad); end
    n_checks++; if (strobe_cnt - bs !== 1) begin n_fail++; $display("FAIL single_strobe_count got %0d want 1", strobe_cnt - bs); end
    n_checks++; if (rsp_cnt - br !== 1) begin n_fail++; $display("FAIL single_rsp_count got %0d want 1", rsp_cnt - br); end
  endtask

  // Ports 0 and 2 together: 1947.0 then 4.0. sqrt(1947)=44.1248 -> 722941.
  task automatic test_simultaneous;
    do_reset();
    req_rad[0] = 32'sh01E6_C000;
    req_rad[2] = 32'sh0001_0000;
    req_valid  = 4'b0101;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL simul_first_ready got %b want 0001", req_ready); end
    serve(32'sd722941, 2, 4'b0001);
    n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL simul_first_rsp got %b want 0001", rsp_valid); end
    n_checks++; if (rsp_root < 32'sd722940 || rsp_root > 32'sd722942) begin n_fail++; $display("FAIL simul_first_root got %0d want 722941+-1", rsp_root); end
    step();
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL simul_second_ready got %b want 0100", req_ready); end
    serve(32'sh0000_8000, 1, 4'b0100);
    n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL simul_second_rsp got %b want 0100", rsp_valid); end
    n_checks++; if (rsp_root !== 32'sh0000_8000) begin n_fail++; $display("FAIL simul_second_root got %h want 00008000", rsp_root); end
    step();
  endtask

  // All four hold req_valid: order 0,1,2,3,0, never two ready bits.
  task automatic test_round_robin;
    int ord[5];
    int mc;
    ord = '{0, 1, 2, 3, 0};
    do_reset();
    mc = multi_cnt;
    for (int p = 0; p < N; p++) req_rad[p] = 32'sh0001_0000 * (p + 1);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (req_ready !== (4'b0001 << ord[k])) begin n_fail++; $display("FAIL rr_ready_%0d got %b want %b", k, req_ready, 4'b0001 << ord[k]); end
      serve(32'sh0000_4000 * (k + 1), 1, 4'b0000);
      n_checks++; if (rsp_valid !== (4'b0001 << ord[k])) begin n_fail++; $display("FAIL rr_rsp_%0d got %b want %b", k, rsp_valid, 4'b0001 << ord[k]); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_ready_busy_%0d got %b want 0000", k, req_ready); end
      if (k == 4) req_valid = '0;
      step();
    end
    n_checks++; if (multi_cnt - mc !== 0) begin n_fail++; $display("FAIL rr_multi_ready got %0d cycles want 0", multi_cnt - mc); end
  endtask

  // Reset during WAIT discards the result; pointer returns to 0.
  task automatic test_reset_mid;
    int br;
    do_reset();
    req_rad[2] = 32'sh0004_0000;
    req_valid  = 4'b0100;
    #1;
    serve(32'sh0000_8000, 1, 4'b0100);
    step();
    req_rad[3] = 32'sh0009_0000;
    req_valid  = 4'b1000;
    step();
    req_valid = '0;
    step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_wait got %b want 1", busy); end
    resetn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_checks++; if (rsp_root !== 32'sh0) begin n_fail++; $display("FAIL rmid_rsp_root got %h want 0", rsp_root); end
    n_checks++; if (sq_rad !== 32'sh0) begin n_fail++; $display("FAIL rmid_sq_rad got %h want 0", sq_rad); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_rsp_valid got %b want 0000", rsp_valid); end
    step();
    resetn = 1'b1;
    br = rsp_cnt;
    sq_valid = 1'b1;
    sq_root  = 32'sh0000_C000;
    step();
    sq_valid = 1'b0;
    step();
    step();
    n_checks++; if (rsp_cnt - br !== 0) begin n_fail++; $display("FAIL rmid_stale_rsp got %0d pulses want 0", rsp_cnt - br); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_after got %b want 0", busy); end
    n_checks++; if (rsp_root !== 32'sh0) begin n_fail++; $display("FAIL rmid_root_after got %h want 0", rsp_root); end
    req_rad[0] = 32'sh0001_0000;
    req_valid  = 4'b1001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr_ready got %b want 0001", req_ready); end
    serve(32'sh0000_4000, 1, 4'b1001);
    n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL rmid_next_rsp got %b want 0001", rsp_valid); end
    n_checks++; if (rsp_root !== 32'sh0000_4000) begin n_fail++; $display("FAIL rmid_next_root got %h want 00004000", rsp_root); end
    step();
  endtask

  // Port 1 requests -4.0.
  task automatic test_negative;
    int bs;
    bs = strobe_cnt;
    req_rad[1] = 32'shFFFF_0000;
    req_valid  = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL neg_ready got %b want 0010", req_ready); end
`ifdef FIXED_SQRT_NEG_CHECK_EN
    step();
    req_valid = '0;
    n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL neg_rsp_valid got %b want 0010", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL neg_rsp_err got %b want 1", rsp_err); end
    n_checks++; if (rsp_root !== 32'sh0) begin n_fail++; $display("FAIL neg_rsp_root got %h want 0", rsp_root); end
    step();
    n_checks++; if (strobe_cnt - bs !== 0) begin n_fail++; $display("FAIL neg_strobe_count got %0d want 0", strobe_cnt - bs); end
`else
    serve(32'sh0000_0000, 1, 4'b0010);
    n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL neg_rsp_valid got %b want 0010", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL neg_rsp_err got %b want 0", rsp_err); end
    n_checks++; if (sq_rad !== 32'shFFFF_0000) begin n_fail++; $display("FAIL neg_sq_rad got %h want ffff0000", sq_rad); end
    step();
    n_checks++; if (strobe_cnt - bs !== 1) begin n_fail++; $display("FAIL neg_strobe_count got %0d want 1", strobe_cnt - bs); end
`endif
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL neg_busy_after got %b want 0", busy); end
  endtask

  // Port 3 glitches req_valid while busy; sq_valid in IDLE is ignored.
  task automatic test_busy_glitch;
    int bs, br;
    bs = strobe_cnt;
    req_rad[0] = 32'sh0001_0000;
    req_valid  = 4'b0001;
    step();
    req_valid = '0;
    step();
    req_valid = 4'b1000;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL glitch_ready_busy got %b want 0000", req_ready); end
    step();
    req_valid = '0;
    sq_valid  = 1'b1;
    sq_root   = 32'sh0000_8000;
    step();
    sq_valid = 1'b0;
    n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL glitch_rsp got %b want 0001", rsp_valid); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_%0d got %b want 0", c, busy); end
    end
    n_checks++; if (strobe_cnt - bs !== 1) begin n_fail++; $display("FAIL glitch_strobe_count got %0d want 1", strobe_cnt - bs); end
    br = rsp_cnt;
    sq_valid = 1'b1;
    sq_root  = 32'sh0000_1111;
    step();
    step();
    sq_valid = 1'b0;
    step();
    n_checks++; if (rsp_cnt - br !== 0) begin n_fail++; $display("FAIL idle_sq_valid_rsp got %0d want 0", rsp_cnt - br); end
    n_checks++; if (rsp_root !== 32'sh0000_8000) begin n_fail++; $display("FAIL idle_sq_valid_root got %h want 00008000", rsp_root); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_sq_valid_busy got %b want 0", busy); end
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_rad   = '0;
    sq_valid  = 1'b0;
    sq_root   = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_reset_mid();
    test_negative();
    test_busy_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_sqrt_arbiter.md
FIXED_SQRT_ARBITER -- requirements
Module: fixed_sqrt_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requester ports (2..8).
REQ-002 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-003 resetn  input  1  SHALL be the asynchronous active-low reset.
REQ-004 req_valid  input  NUM_REQ  SHALL be per-requester request.
REQ-005 req_rad  input  NUM_REQ x Fixed  SHALL be per-requester radicand.
REQ-006 req_ready  output  NUM_REQ  SHALL be per-requester accept (one-hot or zero).
REQ-007 rsp_valid  output  NUM_REQ  SHALL be a one-cycle, one-hot result pulse to the owning requester.
REQ-008 rsp_root  output  Fixed  SHALL be the shared result bus, valid when any rsp_valid bit is high.
REQ-009 rsp_err  output  1  SHALL flag a rejected radicand, qualified by rsp_valid.
REQ-010 sq_strobe  output  1, sq_rad  output  Fixed  SHALL drive the shared sqrt unit's start and radicand.
REQ-011 sq_root  input  Fixed, sq_valid  input  1  SHALL be the shared sqrt unit's result and completion.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: winner = first set req_valid bit searching round-robin from ptr; req_ready[winner]=1 combinationally, same cycle; handshake = req_valid & req_ready.
REQ-015 On handshake: capture winner index and req_rad[winner], go to ISSUE; no handshake, stay in IDLE.
REQ-016 ISSUE: sq_strobe=1 for exactly one cycle with sq_rad = captured radicand; then go to WAIT.
REQ-017 sq_valid SHALL be ignored in IDLE, ISSUE and RESP; it is sampled only in WAIT.
REQ-018 WAIT: on sq_valid=1, capture sq_root and go to RESP; otherwise remain, with no timeout.
REQ-019 RESP: rsp_valid[owner]=1 and rsp_root = captured root for one cycle; ptr <= (owner+1) mod NUM_REQ; go to IDLE.
REQ-020 req_ready SHALL be all-zero outside IDLE; only one operation is in flight.
REQ-021 Latency: handshake cycle to rsp_valid = 2 + L cycles, where L is the number of WAIT cycles; next handshake is possible in the cycle after RESP.
REQ-022 A requester dropping req_valid before its grant SHALL be ignored, with no state change.
REQ-023 Fixed SHALL be 32-bit two's complement with 14 fractional bits; values pass through unmodified.
REQ-024 sq_rad and rsp_root SHALL hold their last value when not qualified.

Reset
REQ-025 Reset SHALL force IDLE and ptr=0, and zero all of req_ready, rsp_valid, rsp_root, rsp_err, sq_strobe, sq_rad and busy.
REQ-026 Reset mid-operation SHALL discard the in-flight result; a later sq_valid SHALL produce no rsp_valid.

Configuration
REQ-027 With FIXED_SQRT_NEG_CHECK_EN defined, an accepted radicand with bit 31 set SHALL go IDLE->RESP directly: no sq_strobe, rsp_root=0, rsp_err=1.
REQ-028 Without FIXED_SQRT_NEG_CHECK_EN, every request SHALL be issued to the unit, and rsp_err SHALL be tied 0.

Structure
REQ-029 The shared package SHALL hold the Fixed type, FRAC_BITS=14, and the FSM state enum.
REQ-030 The round-robin picker (req vector, ptr -> one-hot grant, index) SHALL be sub-module fixed_sqrt_rr_pick.
REQ-031 The sqrt unit SHALL be external to this block.

Verification
REQ-032 Port 0 requests 3.0; unit returns after 3 cycles -> exactly one sq_strobe, rsp_valid=0001, rsp_root=0x6ED9 (1.7320), busy low afterwards.
REQ-033 Ports 0 and 2 request 1947.0 and 4.0 in the same cycle -> port 0 served first (rsp_root 44.1248 +/-1 LSB), then port 2 (rsp_root=0x8000).
REQ-034 All four ports hold req_valid continuously -> grant order 0,1,2,3,0, and never two req_ready bits high at once.
REQ-035 resetn pulsed low during WAIT, then sq_valid arrives -> all outputs 0, no rsp_valid, next request served normally from port 0.
REQ-036 Port 1 requests -4.0 -> with macro: rsp_err=1, rsp_root=0, no sq_strobe; without macro: sq_strobe issued and rsp_err=0.
REQ-037 Port 3 raises req_valid for one cycle while busy and then drops it -> never granted, no extra strobe.
